// File: rtl/regbank_mp.sv
// Single-write, dual-read register bank with memory-mapped I/O ports, working
// register (WR), auxiliary register (AUX) and a WR<->memory transfer FSM.
module regbank_mp #(
  parameter int DATA_W  = 16,
  parameter int NREGS   = 36,
  parameter int ADDR_W  = 6,
  parameter int WR_IDX  = 34,
  parameter int AUX_IDX = 35,
  parameter int PO_BASE = 30,
  parameter int N_PO    = 2,
  parameter int PI_BASE = 28,
  parameter int N_PI    = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [ADDR_W-1:0]        busC,
  input  logic [DATA_W-1:0]        dataC,
  input  logic                     regWrite,
  input  logic [ADDR_W-1:0]        busA,
  input  logic [ADDR_W-1:0]        busB,
  input  logic                     regRead,
  input  logic [1:0]               MC,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [DATA_W-1:0]        mem_wdata,
  input  logic [DATA_W-1:0]        mem_rdata,
  input  logic                     mem_ack,
  output logic                     busy,
  output logic                     mc_err,
  input  logic [N_PI*DATA_W-1:0]   PI,
  output logic [DATA_W-1:0]        A,
  output logic [DATA_W-1:0]        B,
  output logic [DATA_W-1:0]        WRcurrent,
  output logic [DATA_W-1:0]        AUXreg,
  output logic [N_PO*DATA_W-1:0]   PO
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_STORE = 2'd1;
  localparam logic [1:0] S_LOAD  = 2'd2;

  localparam logic [ADDR_W:0]   NREGS_W = (ADDR_W+1)'(NREGS);
  localparam logic [ADDR_W:0]   PI_LO   = (ADDR_W+1)'(PI_BASE);
  localparam logic [ADDR_W:0]   PI_HI   = (ADDR_W+1)'(PI_BASE + N_PI);
  localparam logic [ADDR_W-1:0] WR_SEL  = ADDR_W'(WR_IDX);

  logic [DATA_W-1:0] regs [NREGS];
  logic [1:0]        state;
  logic              load_done;
  logic              write_legal;
  logic [DATA_W-1:0] a_val, b_val, wr_val;

  assign load_done = (state == S_LOAD) && mem_ack;

  // A write to WR colliding with a load completion is dropped: memory data wins.
  assign write_legal = regWrite
                    && ({1'b0, busC} < NREGS_W)
                    && !(({1'b0, busC} >= PI_LO) && ({1'b0, busC} < PI_HI))
                    && !(load_done && busC == WR_SEL);

  // Read values resolve newest-first: legal write, then load completion, then storage.
  always_comb begin
    a_val = '0;
    if ({1'b0, busA} < NREGS_W) a_val = regs[busA];
    if (load_done && busA == WR_SEL) a_val = mem_rdata;
    if (write_legal && busC == busA) a_val = dataC;
  end

  always_comb begin
    b_val = '0;
    if ({1'b0, busB} < NREGS_W) b_val = regs[busB];
    if (load_done && busB == WR_SEL) b_val = mem_rdata;
    if (write_legal && busC == busB) b_val = dataC;
  end

  always_comb begin
    wr_val = regs[WR_IDX];
    if (write_legal && busC == WR_SEL) wr_val = dataC;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      for (int k = 0; k < N_PI; k++) regs[PI_BASE+k] <= PI[k*DATA_W +: DATA_W];
      if (load_done) regs[WR_IDX] <= mem_rdata;
      if (write_legal) regs[busC] <= dataC;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      A <= '0;
      B <= '0;
    end else if (regRead) begin
      A <= a_val;
      B <= b_val;
    end
  end

  // Handshake: mem_req rises the cycle after MC is accepted and stays high with
  // mem_we/mem_wdata stable until the cycle mem_ack is sampled high; the
  // transfer completes on that edge. mem_ack outside a transfer is ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      mem_wdata <= '0;
      mc_err    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (MC[0]) begin
            state     <= S_STORE;
            mem_wdata <= wr_val;
            if (MC[1]) mc_err <= 1'b1;
          end else if (MC[1]) begin
            state <= S_LOAD;
          end
        end
        S_STORE, S_LOAD: if (mem_ack) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign mem_req   = (state != S_IDLE);
  assign busy      = (state != S_IDLE);
  assign mem_we    = (state == S_STORE);
  assign WRcurrent = regs[WR_IDX];
  assign AUXreg    = regs[AUX_IDX];

  for (genvar k = 0; k < N_PO; k++) begin : g_po
    assign PO[k*DATA_W +: DATA_W] = regs[PO_BASE+k];
  end

endmodule

// File: doc/regbank_mp.md
Name: regbank_mp

Overview:
- Parametrised successor to the microsequencer register bank: a single-write, dual-read register file.
- Memory-mapped output ports (PO) and input ports (PI), a dedicated working register (WR) and an auxiliary register (AUX).
- A memory-transfer FSM moves WR to and from data memory under microinstruction MC control with a req/ack handshake.
- Sits between the control unit (bus A/B/C selects) and the ALU/memory interface.

Parameters:
- DATA_W, 16, register and bus width.
- NREGS, 36, number of registers; indices 0..NREGS-1.
- ADDR_W, 6, width of bus select fields; must satisfy 2^ADDR_W >= NREGS.
- WR_IDX, 34, index of the working register.
- AUX_IDX, 35, index of the auxiliary register.
- PO_BASE, 30, first output-port register index.
- N_PO, 2, number of output ports.
- PI_BASE, 28, first input-port register index.
- N_PI, 2, number of input ports.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- busC  in  ADDR_W  write select.
- dataC  in  DATA_W  write data.
- regWrite  in  1  write enable for busC.
- busA  in  ADDR_W  read select, port A.
- busB  in  ADDR_W  read select, port B.
- regRead  in  1  read enable for A and B.
- MC  in  2  bit0 MW (store WR), bit1 MR (load WR); sampled in IDLE only.
- mem_req  out  1  memory request, held until ack.
- mem_we  out  1  1 = store, 0 = load; valid while mem_req is high.
- mem_wdata  out  DATA_W  store data (WR snapshot).
- mem_rdata  in  DATA_W  load data, valid with mem_ack.
- mem_ack  in  1  one-cycle completion strobe.
- busy  out  1  memory transfer in progress.
- mc_err  out  1  sticky: MR and MW were asserted together.
- PI  in  N_PI*DATA_W  input ports, port k at bits [k*DATA_W +: DATA_W].
- A  out  DATA_W  registered operand A.
- B  out  DATA_W  registered operand B.
- WRcurrent  out  DATA_W  live WR contents.
- AUXreg  out  DATA_W  live AUX contents.
- PO  out  N_PO*DATA_W  live output-port registers, same packing as PI.

Behaviour:
- Reset (async, rst_n=0): all registers, A, B, mem_wdata and mc_err go to 0; mem_req=0, mem_we=0, busy=0; FSM to IDLE.
- Reset mid-transfer: transfer is aborted and no WR update happens. mem_req drops asynchronously.
- Write:
  - On a clk edge with regWrite=1, Register[busC] <= dataC.
  - Ignored when busC >= NREGS or busC is in the PI range.
- PI capture:
  - Every cycle, Register[PI_BASE+k] <= PI slot k (one-cycle sampling latency).
  - PI registers are read-only from busC.
- Read:
  - On a clk edge with regRead=1, A <= value(busA) and B <= value(busB); 1-cycle latency.
  - A and B hold their value when regRead=0.
  - Out-of-range select returns 0.
- Read bypass: value(x) returns the newest data.
  - If regWrite=1, busC==x and the write is legal: dataC.
  - Else if a load completes this cycle and x==WR_IDX: mem_rdata.
  - Else: stored contents.
- PO, WRcurrent, AUXreg are continuous copies of their registers; they update the cycle after the write.
- FSM states: IDLE, STORE, LOAD.
  - IDLE, MC=2'b01: mem_wdata <= Register[WR_IDX] (bypassed as above); mem_req=1, mem_we=1, busy=1; go to STORE.
  - IDLE, MC=2'b10: mem_req=1, mem_we=0, busy=1; go to LOAD.
  - IDLE, MC=2'b11: treated as a store; mc_err <= 1, sticky until reset.
  - IDLE, MC=2'b00: stay in IDLE.
  - STORE: hold mem_req, mem_we and mem_wdata stable until mem_ack; on mem_ack return to IDLE (mem_req=0, busy=0 next cycle).
  - LOAD: on mem_ack, Register[WR_IDX] <= mem_rdata and return to IDLE.
  - MC is ignored outside IDLE.
  - mem_ack in IDLE is ignored.
- Write conflict: a regWrite to WR_IDX in the same cycle as a LOAD completion loses; memory data wins. In any other cycle, including while busy, regWrite to WR_IDX proceeds.
- Back-to-back: a new MC is accepted on the first IDLE cycle after completion; minimum transfer is 2 cycles (request cycle + ack cycle).
- Bypass resolves write-before-read; there is no read-before-write hazard.

Test Plan:
- Reset with PO pre-written to 0x1234, then rst_n low mid-cycle -> PO, A, B, WRcurrent read 0 immediately, without waiting for a clock edge.
- regWrite busC=3 dataC=0x00F0 with regRead busA=3 busB=3 in the same cycle -> A=B=0x00F0 one cycle later; writes with busC=40 and busC=28 are ignored (PI slot0=0xBEEF reads back via busA=28 after 2 cycles).
- WR=0x000F, MC=01 -> mem_req=1, mem_we=1, mem_wdata=0x000F held for 3 cycles of delay; ack -> busy=0 next cycle; MC pulses during busy are ignored.
- MC=10, ack with mem_rdata=0xA5A5 while regWrite busC=34 dataC=0x1111 and regRead busA=34 -> WRcurrent=0xA5A5 and A=0xA5A5.
- MC=11 -> store performed, mc_err=1 and stays 1 after two further clean transfers; cleared only by rst_n.
- rst_n asserted during LOAD before ack -> mem_req=0, WR unchanged (still 0 after reset); a later ack in IDLE has no effect.
